fetch_unit: RTL and testbench
=============================

// Module: fetch_unit
// PURPOSE
//  Parametrised MIPS-32 instruction-fetch stage: PC register, internal instruction memory, IF/ID output register.
//  Handles pipeline stall, redirect/flush, and fetch-fault halt. Emits a valid-qualified instruction/PC pair to decode.
//  Sits between the hazard/branch logic (stall_i, redirect_*) and the ID stage.
// PARAMETERS
//  ADDR_W      32          PC / byte-address width
//  IMEM_DEPTH  64          instruction memory depth, in 32-bit words
//  RESET_PC    32'h0       PC value loaded on reset; must be word aligned
// PORTS
//  clk          in   1       single clock; all state changes on posedge
//  rst_n        in   1       synchronous, active-low reset
//  stall_i      in   1       hold PC and IF/ID register
//  redirect_i   in   1       jump/branch taken: load redirect_pc_i, kill in-flight fetch
//  redirect_pc_i in  ADDR_W  redirect target (byte address)
//  imem_we_i    in   1       instruction-memory load strobe
//  imem_waddr_i in   $clog2(IMEM_DEPTH)  word index to write
//  imem_wdata_i in   32      word to write
//  instr_o      out  32      fetched instruction (NOP 32'h0 when invalid)
//  pc_o         out  ADDR_W  byte address of instr_o
//  pc_plus4_o   out  ADDR_W  pc_o + 4, modulo 2^ADDR_W
//  valid_o      out  1       instr_o/pc_o hold a real instruction
//  fetch_err_o  out  1       fault: misaligned PC or word index >= IMEM_DEPTH
// BEHAVIOUR
//  - Reset, rst_n=0 at posedge: pc_q=RESET_PC, instr_o=0, pc_o=0, pc_plus4_o=0, valid_o=0, fetch_err_o=0, state=BOOT.
//    Applies mid-operation too; imem contents are not cleared.
//  - FSM, states BOOT, RUN, HALT:
//    - BOOT: outputs are a bubble for one cycle; then RUN.
//    - RUN: fetches every non-stalled cycle.
//    - HALT: entered after a fault; leaves HALT only on redirect_i (to RUN).
//  - Read path: imem read is combinational at pc_q[ADDR_W-1:2]. IF/ID latency 1: pc_q at cycle n is seen on pc_o at n+1.
//  - Per posedge, priority is reset > redirect > stall > normal:
//    - Redirect: pc_q<=redirect_pc_i; IF/ID <= bubble (valid_o=0, instr_o=0). Honoured even when stall_i=1 or in HALT.
//    - Stall (no redirect): pc_q and every output held unchanged.
//    - Normal: IF/ID <= {mem[pc_q], pc_q, pc_q+4, valid=1}; pc_q<=pc_q+4, wrapping modulo 2^ADDR_W with no fault.
//  - Fault, pc_q[1:0]!=0 or index>=IMEM_DEPTH, in RUN: IF/ID <= {0, pc_q, pc_q+4, valid=1, fetch_err=1}; go to HALT.
//    pc_q frozen; following outputs are bubbles with fetch_err_o=0.
//  - Memory write: imem_we_i writes on posedge independent of stall/FSM state.
//    Same-cycle write and fetch of the same word returns the OLD word. Out-of-range waddr is ignored.
// CONFIGURATION
//  IF_JPREDICT_EN defined:
//    - Fetched word with opcode 6'b000010 (J) or 6'b000011 (JAL) in RUN, no stall, no redirect:
//      pc_q <= {pc_q_plus4[ADDR_W-1:28], instr[25:0], 2'b00} instead of pc_q+4.
//    - No bubble is inserted, and the J is still forwarded to decode with valid_o=1.
//    - An external redirect in the same cycle wins.
//  IF_JPREDICT_EN undefined: J/JAL are treated as ordinary words; decode issues redirect_i.
// STRUCTURE
//  - Package fetch_pkg: fsm state enum (BOOT/RUN/HALT), NOP_INSTR=32'h0, OPC_J=6'b000010, OPC_JAL=6'b000011, PC_INC=4.
//  - Sub-module fetch_imem: IMEM_DEPTH x 32 array, combinational read, synchronous write.
//  - fetch_unit holds the PC, FSM, fault detect, optional J predecode and the IF/ID register.
// TESTING
//  1. Reset, IMEM_DEPTH=64, mem[i]=i+100, rst_n high at cycle 0:
//     cycle 1 valid_o=0; cycle 2 instr_o=100, pc_o=0; cycle 3 instr_o=101, pc_o=4.
//  2. stall_i=1 for 3 cycles while pc_o=8: pc_o=8, instr_o=102 held throughout; resumes at pc_o=12.
//  3. redirect_i=1, target 0x20, coincident with stall_i=1:
//     next cycle valid_o=0; the cycle after, pc_o=0x20, instr_o=108.
//  4. Redirect to 0x102: fetch_err_o=1, pc_o=0x102 for one cycle; then valid_o=0 until redirect to 0x0 restores fetch.
//  5. Redirect to word 64 (0x100), out of range: same fault and HALT. Write to waddr 5 while fetching word 5: old word returned.
//  6. IF_JPREDICT_EN: mem[3]=J target idx 10 (32'h0800000A):
//     pc_o sequence 0x0C then 0x28, with no valid_o=0 between. Without the macro: 0x0C then 0x10.

Source files
------------

// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction-fetch stage.
package fetch_pkg;

    typedef enum logic [1:0] {
        BOOT = 2'd0,
        RUN  = 2'd1,
        HALT = 2'd2
    } fetch_state_t;

    localparam logic [31:0] NOP_INSTR = 32'h0;
    localparam logic [5:0]  OPC_J     = 6'b000010;
    localparam logic [5:0]  OPC_JAL   = 6'b000011;
    localparam int          PC_INC    = 4;

endpackage

// File: rtl/fetch_imem.sv
// Instruction memory: combinational read, synchronous write, contents survive reset.
module fetch_imem #(
    parameter int DEPTH = 64,
    parameter int IDX_W = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             we,
    input  logic [IDX_W-1:0] waddr,
    input  logic [31:0]      wdata,
    input  logic [IDX_W-1:0] raddr,
    output logic [31:0]      rdata
);

    logic [31:0] mem [DEPTH];

    // Read sees the pre-edge contents, so a same-cycle write returns the old word.
    assign rdata = mem[raddr];

    always_ff @(posedge clk) begin
        if (we && (int'(waddr) < DEPTH)) begin
            mem[waddr] <= wdata;
        end
    end

endmodule

// File: rtl/fetch_unit.sv
// MIPS-32 fetch stage: PC, BOOT/RUN/HALT control, fault detect and IF/ID register.
// Optional J/JAL predecode redirect is enabled with `define IF_JPREDICT_EN.
module fetch_unit
    import fetch_pkg::*;
#(
    parameter int                ADDR_W     = 32,
    parameter int                IMEM_DEPTH = 64,
    parameter logic [ADDR_W-1:0] RESET_PC   = '0
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          stall_i,
    input  logic                          redirect_i,
    input  logic [ADDR_W-1:0]             redirect_pc_i,
    input  logic                          imem_we_i,
    input  logic [$clog2(IMEM_DEPTH)-1:0] imem_waddr_i,
    input  logic [31:0]                   imem_wdata_i,
    output logic [31:0]                   instr_o,
    output logic [ADDR_W-1:0]             pc_o,
    output logic [ADDR_W-1:0]             pc_plus4_o,
    output logic                          valid_o,
    output logic                          fetch_err_o
);

    localparam int IDX_W = $clog2(IMEM_DEPTH);

    fetch_state_t      state_q, state_d;
    logic [ADDR_W-1:0] pc_q, pc_d;
    logic [31:0]       instr_q, instr_d;
    logic [ADDR_W-1:0] out_pc_q, out_pc_d;
    logic [ADDR_W-1:0] out_pc4_q, out_pc4_d;
    logic              valid_q, valid_d;
    logic              err_q, err_d;

    logic [31:0]       imem_rdata;
    logic [ADDR_W-1:0] pc_plus4;
    logic              fault;

    fetch_imem #(
        .DEPTH (IMEM_DEPTH),
        .IDX_W (IDX_W)
    ) u_imem (
        .clk   (clk),
        .we    (imem_we_i),
        .waddr (imem_waddr_i),
        .wdata (imem_wdata_i),
        .raddr (pc_q[IDX_W+1:2]),
        .rdata (imem_rdata)
    );

    assign pc_plus4 = pc_q + ADDR_W'(PC_INC);
    assign fault    = (pc_q[1:0] != 2'b00) ||
                      (pc_q[ADDR_W-1:2] >= (ADDR_W-2)'(IMEM_DEPTH));

    always_comb begin
        state_d   = state_q;
        pc_d      = pc_q;
        instr_d   = instr_q;
        out_pc_d  = out_pc_q;
        out_pc4_d = out_pc4_q;
        valid_d   = valid_q;
        err_d     = err_q;

        if (redirect_i) begin
            // Redirect kills the in-flight fetch and also recovers from HALT.
            pc_d      = redirect_pc_i;
            state_d   = RUN;
            instr_d   = NOP_INSTR;
            out_pc_d  = '0;
            out_pc4_d = '0;
            valid_d   = 1'b0;
            err_d     = 1'b0;
        end else if (!stall_i) begin
            instr_d   = NOP_INSTR;
            out_pc_d  = '0;
            out_pc4_d = '0;
            valid_d   = 1'b0;
            err_d     = 1'b0;
            case (state_q)
                BOOT: state_d = RUN;
                RUN: begin
                    out_pc_d  = pc_q;
                    out_pc4_d = pc_plus4;
                    valid_d   = 1'b1;
                    if (fault) begin
                        err_d   = 1'b1;
                        state_d = HALT;
                    end else begin
                        instr_d = imem_rdata;
                        pc_d    = pc_plus4;
`ifdef IF_JPREDICT_EN
                        if ((imem_rdata[31:26] == OPC_J) || (imem_rdata[31:26] == OPC_JAL)) begin
                            pc_d = {pc_plus4[ADDR_W-1:28], imem_rdata[25:0], 2'b00};
                        end
`endif
                    end
                end
                HALT: state_d = HALT;
                default: state_d = BOOT;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q   <= BOOT;
            pc_q      <= RESET_PC;
            instr_q   <= NOP_INSTR;
            out_pc_q  <= '0;
            out_pc4_q <= '0;
            valid_q   <= 1'b0;
            err_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            pc_q      <= pc_d;
            instr_q   <= instr_d;
            out_pc_q  <= out_pc_d;
            out_pc4_q <= out_pc4_d;
            valid_q   <= valid_d;
            err_q     <= err_d;
        end
    end

    assign instr_o     = instr_q;
    assign pc_o        = out_pc_q;
    assign pc_plus4_o  = out_pc4_q;
    assign valid_o     = valid_q;
    assign fetch_err_o = err_q;

endmodule

// File: tb/tb_fetch_unit.sv
// Bench for fetch_unit: directed scenarios then random traffic, checked against a rule-level model.
module tb_fetch_unit;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        stall_i = 1'b0;
    logic        redirect_i = 1'b0;
    logic [31:0] redirect_pc_i = '0;
    logic        imem_we_i = 1'b0;
    logic [5:0]  imem_waddr_i = '0;
    logic [31:0] imem_wdata_i = '0;
    logic [31:0] instr_o, pc_o, pc_plus4_o;
    logic        valid_o, fetch_err_o;

    int n_tests = 0;
    int n_fail  = 0;

    fetch_unit #(.ADDR_W(32), .IMEM_DEPTH(64), .RESET_PC(32'h0)) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .stall_i       (stall_i),
        .redirect_i    (redirect_i),
        .redirect_pc_i (redirect_pc_i),
        .imem_we_i     (imem_we_i),
        .imem_waddr_i  (imem_waddr_i),
        .imem_wdata_i  (imem_wdata_i),
        .instr_o       (instr_o),
        .pc_o          (pc_o),
        .pc_plus4_o    (pc_plus4_o),
        .valid_o       (valid_o),
        .fetch_err_o   (fetch_err_o)
    );

    always #5 clk = ~clk;

    // Reference model: mode 0 = just out of reset, 1 = fetching, 2 = halted on a fault.
    logic [31:0] m_mem [64];
    int          m_mode;
    logic [31:0] m_pc;
    logic [31:0] e_instr, e_pc, e_pc4;
    logic        e_valid, e_err;

    task automatic bubble();
        e_instr = 0; e_pc = 0; e_pc4 = 0; e_valid = 0; e_err = 0;
    endtask

    task automatic model_step();
        logic [31:0] word;
        if (!rst_n) begin
            m_pc = 0; m_mode = 0; bubble();
        end else if (redirect_i) begin
            m_pc = redirect_pc_i; m_mode = 1; bubble();
        end else if (!stall_i) begin
            if (m_mode == 0) begin
                bubble(); m_mode = 1;
            end else if (m_mode == 2) begin
                bubble();
            end else if ((m_pc % 4 != 0) || (m_pc / 4 >= 64)) begin
                e_instr = 0; e_pc = m_pc; e_pc4 = m_pc + 4; e_valid = 1; e_err = 1;
                m_mode = 2;
            end else begin
                word = m_mem[m_pc / 4];
                e_instr = word; e_pc = m_pc; e_pc4 = m_pc + 4; e_valid = 1; e_err = 0;
                m_pc = m_pc + 4;
`ifdef IF_JPREDICT_EN
                if (word[31:26] == 6'd2 || word[31:26] == 6'd3)
                    m_pc = {e_pc4[31:28], word[25:0], 2'b00};
`endif
            end
        end
        if (imem_we_i) m_mem[imem_waddr_i] = imem_wdata_i;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // One clock: model follows the edge, then every output is compared.
    task automatic step();
        @(posedge clk);
        model_step();
        #1;
        chk("instr", instr_o, e_instr);
        chk("pc", pc_o, e_pc);
        chk("pc_plus4", pc_plus4_o, e_pc4);
        chk("valid", 32'(valid_o), 32'(e_valid));
        chk("fetch_err", 32'(fetch_err_o), 32'(e_err));
    endtask

    task automatic redirect_to(input logic [31:0] target, input logic with_stall);
        redirect_i = 1; redirect_pc_i = target; stall_i = with_stall;
        step();
        chk("redirect_bubble", 32'(valid_o), 32'd0);
        redirect_i = 0; stall_i = 0;
    endtask

    initial begin
        // Load memory while held in reset; outputs must stay at their reset values.
        rst_n = 0;
        imem_we_i = 1;
        for (int i = 0; i < 64; i++) begin
            imem_waddr_i = 6'(i); imem_wdata_i = 32'(i + 100);
            step();
        end
        imem_we_i = 0;
        chk("reset_valid", 32'(valid_o), 32'd0);
        chk("reset_pc", pc_o, 32'd0);

        // Boot bubble then sequential fetch.
        rst_n = 1;
        step(); chk("boot_bubble", 32'(valid_o), 32'd0);
        step(); chk("first_instr", instr_o, 32'd100); chk("first_pc", pc_o, 32'h0);
        step(); chk("second_instr", instr_o, 32'd101); chk("second_pc", pc_o, 32'h4);
        step(); chk("third_pc", pc_o, 32'h8);

        // Stall holds the IF/ID contents.
        stall_i = 1;
        for (int i = 0; i < 3; i++) begin
            step(); chk("stall_pc", pc_o, 32'h8); chk("stall_instr", instr_o, 32'd102);
        end
        stall_i = 0;
        step(); chk("resume_pc", pc_o, 32'hC);

        // Redirect wins over a coincident stall.
        redirect_to(32'h20, 1'b1);
        step(); chk("redir_pc", pc_o, 32'h20); chk("redir_instr", instr_o, 32'd108);

        // Misaligned target: one fault cycle, then halted bubbles.
        redirect_to(32'h102, 1'b0);
        step(); chk("misalign_err", 32'(fetch_err_o), 32'd1); chk("misalign_pc", pc_o, 32'h102);
        for (int i = 0; i < 3; i++) begin
            step(); chk("halt_valid", 32'(valid_o), 32'd0); chk("halt_err", 32'(fetch_err_o), 32'd0);
        end
        redirect_to(32'h0, 1'b0);
        step(); chk("recover_instr", instr_o, 32'd100);

        // Word index past the end of memory.
        redirect_to(32'h100, 1'b0);
        step(); chk("range_err", 32'(fetch_err_o), 32'd1); chk("range_pc", pc_o, 32'h100);
        step(); chk("range_halt", 32'(valid_o), 32'd0);

        // Write and fetch the same word on the same edge: old word returned.
        redirect_to(32'h14, 1'b0);
        imem_we_i = 1; imem_waddr_i = 6'd5; imem_wdata_i = 32'hDEAD_BEEF;
        step(); chk("wr_old_word", instr_o, 32'd105);
        imem_we_i = 0;
        redirect_to(32'h14, 1'b0);
        step(); chk("wr_new_word", instr_o, 32'hDEAD_BEEF);

        // J at word 3 targeting word 10.
        imem_we_i = 1; imem_waddr_i = 6'd3; imem_wdata_i = 32'h0800_000A;
        step();
        imem_we_i = 0;
        redirect_to(32'h0, 1'b0);
        for (int i = 0; i < 4; i++) step();
        chk("j_pc", pc_o, 32'hC); chk("j_valid", 32'(valid_o), 32'd1);
        step(); chk("after_j_valid", 32'(valid_o), 32'd1);
`ifdef IF_JPREDICT_EN
        chk("after_j_pc", pc_o, 32'h28);
`else
        chk("after_j_pc", pc_o, 32'h10);
`endif

        // Mid-operation reset keeps memory but restarts at RESET_PC.
        rst_n = 0; step();
        rst_n = 1; step(); step();
        chk("rereset_instr", instr_o, 32'd100);

        // Random traffic.
        for (int i = 0; i < 400; i++) begin
            rst_n      = ($urandom_range(0, 99) >= 2);
            stall_i    = ($urandom_range(0, 3) == 0);
            redirect_i = ($urandom_range(0, 9) == 0);
            case ($urandom_range(0, 7))
                0: redirect_pc_i = {24'h0, 6'($urandom_range(0, 63)), 2'($urandom_range(1, 3))};
                1: redirect_pc_i = 32'($urandom_range(64, 80)) << 2;
                default: redirect_pc_i = 32'($urandom_range(0, 63)) << 2;
            endcase
            imem_we_i    = ($urandom_range(0, 3) == 0);
            imem_waddr_i = 6'($urandom_range(0, 63));
            if ($urandom_range(0, 7) == 0)
                imem_wdata_i = 32'h0800_0000 | 32'($urandom_range(0, 70));
            else
                imem_wdata_i = 32'($urandom_range(0, 255));
            step();
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
